// File: rtl/keyiv_serializer_if.sv
// rtl/keyiv_serializer_if.sv - load handshake and serial output bundle for keyiv_serializer
// stall_i is present only when KEYIV_SER_STALL_EN is defined
interface keyiv_serializer_if #(
  parameter int KEY_SZ = 80,
  parameter int IV_SZ  = 80
);
  logic              valid_i;
`ifdef KEYIV_SER_STALL_EN
  logic              stall_i;
`endif
  logic              ready_o;
  logic [KEY_SZ-1:0] key_i;
  logic [IV_SZ-1:0]  iv_i;
  logic              ser_dat_o;
  logic              ser_ce_o;
  logic              busy_o;
  logic              done_o;

`ifdef KEYIV_SER_STALL_EN
  modport master (
    output valid_i, stall_i, key_i, iv_i,
    input  ready_o, ser_dat_o, ser_ce_o, busy_o, done_o
  );

  modport slave (
    input  valid_i, stall_i, key_i, iv_i,
    output ready_o, ser_dat_o, ser_ce_o, busy_o, done_o
  );
`else
  modport master (
    output valid_i, key_i, iv_i,
    input  ready_o, ser_dat_o, ser_ce_o, busy_o, done_o
  );

  modport slave (
    input  valid_i, key_i, iv_i,
    output ready_o, ser_dat_o, ser_ce_o, busy_o, done_o
  );
`endif

endinterface

// File: rtl/keyiv_serializer.sv
// rtl/keyiv_serializer.sv - serializes IV then key, LSB first, into a key/IV shift register
// Optional KEYIV_SER_STALL_EN adds stall_i, which freezes shifting while high.
module keyiv_serializer #(
  parameter int KEY_SZ = 80,
  parameter int IV_SZ  = 80
) (
  input  logic               clk_i,
  input  logic               n_rst_i,
  keyiv_serializer_if.slave  bus
);

  localparam int DATA_W = KEY_SZ + IV_SZ;
  localparam int MAX_SZ = (KEY_SZ > IV_SZ) ? KEY_SZ : IV_SZ;
  localparam int CNT_W  = $clog2(MAX_SZ + 1);
  localparam logic [CNT_W-1:0] IV_LAST  = CNT_W'(IV_SZ - 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_SZ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_IV  = 2'd1,
    SHIFT_KEY = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              shifting;
  logic              shift_en;

  assign shifting = (state_q == SHIFT_IV) || (state_q == SHIFT_KEY);

`ifdef KEYIV_SER_STALL_EN
  assign shift_en = shifting && !bus.stall_i;
`else
  assign shift_en = shifting;
`endif

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Field boundaries are detected on the last bit so each phase takes exactly its width in enabled cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          data_d  = {bus.key_i, bus.iv_i};
          cnt_d   = '0;
          state_d = SHIFT_IV;
        end
      end
      SHIFT_IV: begin
        if (shift_en) begin
          data_d = {1'b0, data_q[DATA_W-1:1]};
          if (cnt_q == IV_LAST) begin
            cnt_d   = '0;
            state_d = SHIFT_KEY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SHIFT_KEY: begin
        if (shift_en) begin
          data_d = {1'b0, data_q[DATA_W-1:1]};
          if (cnt_q == KEY_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready_o   = (state_q == IDLE);
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = (state_q == DONE);
  assign bus.ser_ce_o  = shift_en;
  assign bus.ser_dat_o = data_q[0];

endmodule
